// File: rtl/mips_core_pkg.sv
// -----------------------------------------------------------------------------
// mips_core_pkg
// Purpose : Shared types and sizing constants for the out-of-order core.
//           The issue queue imports the instruction payload type and its
//           default sizes from here.
// Contents: INSTR_QUEUE_SIZE, DEFAULT_PREG_W, Instr_Queue_Entry_t,
//           is_younger() age-compare helper.
// -----------------------------------------------------------------------------
package mips_core_pkg;

    localparam int INSTR_QUEUE_SIZE = 8;
    localparam int DEFAULT_PREG_W   = 6;

    // Payload carried through the issue queue. instr_count is the program-order
    // sequence number: a larger value is a younger instruction.
    typedef struct packed {
        logic [31:0]               instr_count;
        logic [DEFAULT_PREG_W-1:0] rs_phys;
        logic [DEFAULT_PREG_W-1:0] rt_phys;
        logic [DEFAULT_PREG_W-1:0] rw_phys;
        logic                      uses_rs;
        logic                      uses_rt;
    } Instr_Queue_Entry_t;

    // True when an instruction lies strictly after the squash boundary.
    function automatic logic is_younger(input logic [31:0] count,
                                        input logic [31:0] boundary);
        return (count > boundary);
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// -----------------------------------------------------------------------------
// issue_queue_if
// Purpose : Groups the enqueue (rename -> queue) and issue (queue -> execute)
//           handshakes of the issue queue.
// Signals : enq_valid/enq_ready/enq_entry  enqueue side
//           iss_valid/iss_ready/iss_entry  issue side
// Modports: slave  - the issue queue itself
//           master - the environment (rename stage + execute stage)
// -----------------------------------------------------------------------------
interface issue_queue_if;
    import mips_core_pkg::*;

    logic               enq_valid;
    logic               enq_ready;
    Instr_Queue_Entry_t enq_entry;
    logic               iss_valid;
    logic               iss_ready;
    Instr_Queue_Entry_t iss_entry;

    modport slave (
        input  enq_valid, enq_entry, iss_ready,
        output enq_ready, iss_valid, iss_entry
    );

    modport master (
        output enq_valid, enq_entry, iss_ready,
        input  enq_ready, iss_valid, iss_entry
    );

endinterface

// File: rtl/iq_oldest_select.sv
// -----------------------------------------------------------------------------
// iq_oldest_select
// Purpose : Picks the eligible slot with the smallest instr_count.
// Ports   : eligible [DEPTH]      per-slot ready-to-issue flags
//           counts   [DEPTH][32]  per-slot instr_count
//           grant    [DEPTH]      one-hot winner (all zero when none)
//           found                 at least one slot was eligible
// Counts are unique in flight, so strict '<' never meets a tie.
// -----------------------------------------------------------------------------
module iq_oldest_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]       eligible,
    input  logic [DEPTH-1:0][31:0] counts,
    output logic [DEPTH-1:0]       grant,
    output logic                   found
);

    localparam int IDX_W = $clog2(DEPTH);

    logic             found_s;
    logic             take_s;
    logic [31:0]      best_cnt_s;
    logic [IDX_W-1:0] best_idx_s;

    // Linear scan keeping the oldest eligible slot seen so far.
    always_comb begin
        found_s    = 1'b0;
        take_s     = 1'b0;
        best_cnt_s = 32'd0;
        best_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            take_s     = eligible[i] & (~found_s | (counts[i] < best_cnt_s));
            best_cnt_s = take_s ? counts[i] : best_cnt_s;
            best_idx_s = take_s ? IDX_W'(i) : best_idx_s;
            found_s    = found_s | take_s;
        end
    end

    // Expand the winning index into a one-hot grant.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = found_s & (best_idx_s == IDX_W'(i));
        end
        found = found_s;
    end

endmodule

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
// Purpose : Out-of-order instruction issue queue. Holds renamed instructions
//           until both source operands are ready, then issues the oldest
//           ready one through a registered output stage.
// Ports   : clk, rst_n                 clock, async active-low reset
//           q_if (slave)               enqueue and issue handshakes
//           busy_bits[NUM_PREGS]       1 = physical register value pending
//           wake_valid/wake_tag        result-tag broadcasts
//           flush, flush_count         squash everything younger than count
//           occupancy, empty           fill level (slots only) / fully idle
// -----------------------------------------------------------------------------
module issue_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = INSTR_QUEUE_SIZE,
    parameter int PREG_W     = DEFAULT_PREG_W,
    parameter int WAKE_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    issue_queue_if.slave                        q_if,
    input  logic [(2**PREG_W)-1:0]              busy_bits,
    input  logic [WAKE_PORTS-1:0]               wake_valid,
    input  logic [WAKE_PORTS-1:0][PREG_W-1:0]   wake_tag,
    input  logic                                flush,
    input  logic [31:0]                         flush_count,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy,
    output logic                                empty
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    // Slot storage
    logic [DEPTH-1:0]   slot_valid_q, slot_valid_d;
    logic [DEPTH-1:0]   rs_rdy_q,     rs_rdy_d;
    logic [DEPTH-1:0]   rt_rdy_q,     rt_rdy_d;
    Instr_Queue_Entry_t slot_entry_q [DEPTH];
    Instr_Queue_Entry_t slot_entry_d [DEPTH];

    // Output stage and fill level
    logic               iss_valid_q, iss_valid_d;
    Instr_Queue_Entry_t iss_entry_q, iss_entry_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;

    // Combinational helpers
    logic                   enq_ready_s;
    logic                   enq_fire_s;
    logic [IDX_W-1:0]       free_idx_s;
    logic                   free_found_s;
    logic                   free_take_s;
    logic [DEPTH-1:0]       eligible_s;
    logic [DEPTH-1:0][31:0] counts_s;
    logic [DEPTH-1:0]       grant_s;
    logic                   sel_found_s;
    logic                   can_load_s;
    Instr_Queue_Entry_t     sel_entry_s;

    // True when any asserted broadcast carries this tag.
    function automatic logic tag_woken(input logic [WAKE_PORTS-1:0]             wv,
                                       input logic [WAKE_PORTS-1:0][PREG_W-1:0] wt,
                                       input logic [DEFAULT_PREG_W-1:0]         tag);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            hit = hit | (wv[p] & (wt[p] == tag));
        end
        return hit;
    endfunction

    // Readiness is judged on registered occupancy, so a slot freed by this
    // cycle's issue only becomes reusable next cycle.
    assign enq_ready_s    = (occupancy_q < OCC_W'(DEPTH)) & ~flush;
    assign enq_fire_s     = q_if.enq_valid & enq_ready_s;
    assign q_if.enq_ready = enq_ready_s;
    assign q_if.iss_valid = iss_valid_q;
    assign q_if.iss_entry = iss_entry_q;
    assign occupancy      = occupancy_q;
    assign empty          = (occupancy_q == OCC_W'(0)) & ~iss_valid_q;

    // Lowest-index free slot for the incoming instruction.
    always_comb begin
        free_idx_s   = '0;
        free_found_s = 1'b0;
        free_take_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            free_take_s  = ~slot_valid_q[i] & ~free_found_s;
            free_idx_s   = free_take_s ? IDX_W'(i) : free_idx_s;
            free_found_s = free_found_s | free_take_s;
        end
    end

    // Eligibility uses registered ready bits: a wakeup takes one edge to land.
    always_comb begin
        eligible_s = slot_valid_q & rs_rdy_q & rt_rdy_q;
        counts_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            counts_s[i] = slot_entry_q[i].instr_count;
        end
    end

    iq_oldest_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .eligible (eligible_s),
        .counts   (counts_s),
        .grant    (grant_s),
        .found    (sel_found_s)
    );

    // Mux the granted slot's payload toward the output register.
    always_comb begin
        sel_entry_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_entry_s = grant_s[i] ? slot_entry_q[i] : sel_entry_s;
        end
    end

    // Output register may take a new entry when empty or being consumed; a
    // flush cycle never loads.
    assign can_load_s = ~flush & sel_found_s & (~iss_valid_q | q_if.iss_ready);

    // Next state of every slot: issue-free, squash, wakeup, enqueue write.
    always_comb begin
        slot_valid_d = slot_valid_q;
        rs_rdy_d     = rs_rdy_q;
        rt_rdy_d     = rt_rdy_q;
        for (int i = 0; i < DEPTH; i++) begin
            slot_entry_d[i] = slot_entry_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid_d[i] = slot_valid_q[i]
                            & ~(grant_s[i] & can_load_s)
                            & ~(flush & is_younger(slot_entry_q[i].instr_count, flush_count));
            rs_rdy_d[i] = rs_rdy_q[i] | tag_woken(wake_valid, wake_tag, slot_entry_q[i].rs_phys);
            rt_rdy_d[i] = rt_rdy_q[i] | tag_woken(wake_valid, wake_tag, slot_entry_q[i].rt_phys);
            if (enq_fire_s && (free_idx_s == IDX_W'(i))) begin
                slot_valid_d[i] = 1'b1;
                slot_entry_d[i] = q_if.enq_entry;
                rs_rdy_d[i]     = ~q_if.enq_entry.uses_rs
                                | ~busy_bits[q_if.enq_entry.rs_phys]
                                | tag_woken(wake_valid, wake_tag, q_if.enq_entry.rs_phys);
                rt_rdy_d[i]     = ~q_if.enq_entry.uses_rt
                                | ~busy_bits[q_if.enq_entry.rt_phys]
                                | tag_woken(wake_valid, wake_tag, q_if.enq_entry.rt_phys);
            end else begin
                slot_entry_d[i] = slot_entry_q[i];
            end
        end
    end

    // Slot count after this edge; the output register is not included.
    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + OCC_W'(slot_valid_d[i]);
        end
    end

    // Output stage: load, drain, or hold under stall; a squash can kill it.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_entry_d = iss_entry_q;
        if (can_load_s) begin
            iss_valid_d = 1'b1;
            iss_entry_d = sel_entry_s;
        end else if (q_if.iss_ready) begin
            iss_valid_d = 1'b0;
        end else begin
            iss_valid_d = iss_valid_q;
        end
        if (flush && is_younger(iss_entry_q.instr_count, flush_count)) begin
            iss_valid_d = 1'b0;
        end else begin
            iss_valid_d = iss_valid_d;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            rs_rdy_q     <= '0;
            rt_rdy_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_entry_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            rs_rdy_q     <= rs_rdy_d;
            rt_rdy_q     <= rt_rdy_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_entry_q[i] <= slot_entry_d[i];
            end
        end
    end

    // Output stage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_entry_q <= '0;
            occupancy_q <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_entry_q <= iss_entry_d;
            occupancy_q <= occupancy_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
// Directed scenarios for the issue queue; inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_issue_queue;
    import mips_core_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [63:0]        busy_bits;
    logic [1:0]         wake_valid;
    logic [1:0][5:0]    wake_tag;
    logic               flush;
    logic [31:0]        flush_count;
    logic [3:0]         occupancy;
    logic               empty;

    int vectors;
    int miscompares;

    issue_queue_if q_if ();

    issue_queue #(
        .DEPTH      (8),
        .PREG_W     (6),
        .WAKE_PORTS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .q_if        (q_if),
        .busy_bits   (busy_bits),
        .wake_valid  (wake_valid),
        .wake_tag    (wake_tag),
        .flush       (flush),
        .flush_count (flush_count),
        .occupancy   (occupancy),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic Instr_Queue_Entry_t mk(input int cnt, input logic [5:0] rs,
                                              input logic [5:0] rt, input logic urs,
                                              input logic urt);
        Instr_Queue_Entry_t e;
        e.instr_count = 32'(cnt);
        e.rs_phys     = rs;
        e.rt_phys     = rt;
        e.rw_phys     = 6'd33;
        e.uses_rs     = urs;
        e.uses_rt     = urt;
        return e;
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        q_if.enq_valid = 1'b0;
        q_if.enq_entry = '0;
        q_if.iss_ready = 1'b1;
        busy_bits      = '0;
        wake_valid     = '0;
        wake_tag       = '0;
        flush          = 1'b0;
        flush_count    = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (q_if.iss_valid !== 1'b0) begin miscompares++; $display("FAIL rst_iss_valid: got %b want 0", q_if.iss_valid); end
        vectors++; if (q_if.iss_entry !== '0) begin miscompares++; $display("FAIL rst_iss_entry: got %h want 0", q_if.iss_entry); end
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        vectors++; if (q_if.enq_ready !== 1'b1) begin miscompares++; $display("FAIL rst_enq_ready: got %b want 1", q_if.enq_ready); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b want 1", empty); end
    endtask

    task automatic test_in_order();
        do_reset();
        q_if.enq_valid = 1'b1;
        q_if.enq_entry = mk(10, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b0) begin miscompares++; $display("FAIL ord_latency: got %b want 0", q_if.iss_valid); end
        vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL ord_occ0: got %0d want 1", occupancy); end
        q_if.enq_entry = mk(11, 6'd3, 6'd4, 1'b1, 1'b1);
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd10) begin miscompares++; $display("FAIL ord_first: got v=%b cnt=%0d want v=1 cnt=10", q_if.iss_valid, q_if.iss_entry.instr_count); end
        vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL ord_occ_net0: got %0d want 1", occupancy); end
        q_if.enq_entry = mk(12, 6'd5, 6'd6, 1'b1, 1'b0);
        @(negedge clk);
        vectors++; if (q_if.iss_entry.instr_count !== 32'd11) begin miscompares++; $display("FAIL ord_second: got %0d want 11", q_if.iss_entry.instr_count); end
        q_if.enq_valid = 1'b0;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd12) begin miscompares++; $display("FAIL ord_third: got v=%b cnt=%0d want v=1 cnt=12", q_if.iss_valid, q_if.iss_entry.instr_count); end
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL ord_occ_end: got %0d want 0", occupancy); end
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL ord_drain: got v=%b empty=%b want v=0 empty=1", q_if.iss_valid, empty); end
    endtask

    task automatic test_wakeup();
        do_reset();
        busy_bits[7]   = 1'b1;
        q_if.enq_valid = 1'b1;
        q_if.enq_entry = mk(5, 6'd7, 6'd0, 1'b1, 1'b0);
        @(negedge clk);
        q_if.enq_entry = mk(6, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b0) begin miscompares++; $display("FAIL wk_blocked: got %b want 0", q_if.iss_valid); end
        q_if.enq_valid = 1'b0;
        wake_valid     = 2'b01;
        wake_tag[0]    = 6'd7;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd6) begin miscompares++; $display("FAIL wk_young_first: got v=%b cnt=%0d want v=1 cnt=6", q_if.iss_valid, q_if.iss_entry.instr_count); end
        wake_valid = 2'b00;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd5) begin miscompares++; $display("FAIL wk_woken: got v=%b cnt=%0d want v=1 cnt=5", q_if.iss_valid, q_if.iss_entry.instr_count); end
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL wk_occ: got %0d want 0", occupancy); end
        // Same-cycle wakeup on port 1 while enqueuing a busy operand.
        busy_bits[9]   = 1'b1;
        q_if.enq_valid = 1'b1;
        q_if.enq_entry = mk(30, 6'd12, 6'd9, 1'b0, 1'b1);
        wake_valid     = 2'b10;
        wake_tag[1]    = 6'd9;
        @(negedge clk);
        q_if.enq_valid = 1'b0;
        wake_valid     = 2'b00;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd30) begin miscompares++; $display("FAIL wk_enq_bypass: got v=%b cnt=%0d want v=1 cnt=30", q_if.iss_valid, q_if.iss_entry.instr_count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) busy_bits[10+i] = 1'b1;
        q_if.enq_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q_if.enq_entry = mk(40 + i, 6'(10 + i), 6'd0, 1'b1, 1'b0);
            @(negedge clk);
        end
        q_if.enq_valid = 1'b0;
        vectors++; if (occupancy !== 4'd8) begin miscompares++; $display("FAIL full_occ: got %0d want 8", occupancy); end
        vectors++; if (q_if.enq_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", q_if.enq_ready); end
        q_if.enq_valid = 1'b1;
        q_if.enq_entry = mk(60, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        q_if.enq_valid = 1'b0;
        vectors++; if (occupancy !== 4'd8 || q_if.iss_valid !== 1'b0) begin miscompares++; $display("FAIL full_overflow: got occ=%0d v=%b want occ=8 v=0", occupancy, q_if.iss_valid); end
        wake_valid  = 2'b01;
        wake_tag[0] = 6'd10;
        @(negedge clk);
        wake_valid = 2'b00;
        vectors++; if (q_if.enq_ready !== 1'b0 || occupancy !== 4'd8) begin miscompares++; $display("FAIL full_wake_edge: got rdy=%b occ=%0d want rdy=0 occ=8", q_if.enq_ready, occupancy); end
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd40) begin miscompares++; $display("FAIL full_issue: got v=%b cnt=%0d want v=1 cnt=40", q_if.iss_valid, q_if.iss_entry.instr_count); end
        vectors++; if (q_if.enq_ready !== 1'b1 || occupancy !== 4'd7) begin miscompares++; $display("FAIL full_reopen: got rdy=%b occ=%0d want rdy=1 occ=7", q_if.enq_ready, occupancy); end
    endtask

    task automatic test_stall();
        do_reset();
        q_if.iss_ready = 1'b0;
        q_if.enq_valid = 1'b1;
        q_if.enq_entry = mk(50, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        q_if.enq_entry = mk(51, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd50) begin miscompares++; $display("FAIL stall_c1: got v=%b cnt=%0d want v=1 cnt=50", q_if.iss_valid, q_if.iss_entry.instr_count); end
        q_if.enq_entry = mk(52, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd50) begin miscompares++; $display("FAIL stall_c2: got v=%b cnt=%0d want v=1 cnt=50", q_if.iss_valid, q_if.iss_entry.instr_count); end
        vectors++; if (occupancy !== 4'd2) begin miscompares++; $display("FAIL stall_occ2: got %0d want 2", occupancy); end
        q_if.enq_valid = 1'b0;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd50 || occupancy !== 4'd2) begin miscompares++; $display("FAIL stall_c3: got v=%b cnt=%0d occ=%0d want v=1 cnt=50 occ=2", q_if.iss_valid, q_if.iss_entry.instr_count, occupancy); end
        q_if.iss_ready = 1'b1;
        @(negedge clk);
        vectors++; if (q_if.iss_entry.instr_count !== 32'd51 || occupancy !== 4'd1) begin miscompares++; $display("FAIL stall_release: got cnt=%0d occ=%0d want cnt=51 occ=1", q_if.iss_entry.instr_count, occupancy); end
        @(negedge clk);
        vectors++; if (q_if.iss_entry.instr_count !== 32'd52 || q_if.iss_valid !== 1'b1) begin miscompares++; $display("FAIL stall_next: got v=%b cnt=%0d want v=1 cnt=52", q_if.iss_valid, q_if.iss_entry.instr_count); end
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain: got %b want 0", q_if.iss_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        busy_bits[5]   = 1'b1;
        q_if.enq_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q_if.enq_entry = mk(20 + i, 6'd5, 6'd0, 1'b1, 1'b0);
            @(negedge clk);
        end
        vectors++; if (occupancy !== 4'd8) begin miscompares++; $display("FAIL fl_fill: got %0d want 8", occupancy); end
        flush          = 1'b1;
        flush_count    = 32'd23;
        q_if.enq_entry = mk(99, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        vectors++; if (occupancy !== 4'd4 || q_if.iss_valid !== 1'b0) begin miscompares++; $display("FAIL fl_squash: got occ=%0d v=%b want occ=4 v=0", occupancy, q_if.iss_valid); end
        flush_count = 32'd30;
        #1;
        vectors++; if (q_if.enq_ready !== 1'b0) begin miscompares++; $display("FAIL fl_enq_block: got %b want 0", q_if.enq_ready); end
        @(negedge clk);
        vectors++; if (occupancy !== 4'd4) begin miscompares++; $display("FAIL fl_enq_ignored: got %0d want 4", occupancy); end
        flush          = 1'b0;
        q_if.enq_valid = 1'b0;
        q_if.iss_ready = 1'b0;
        wake_valid     = 2'b01;
        wake_tag[0]    = 6'd5;
        @(negedge clk);
        wake_valid = 2'b00;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || q_if.iss_entry.instr_count !== 32'd20 || occupancy !== 4'd3) begin miscompares++; $display("FAIL fl_survivor: got v=%b cnt=%0d occ=%0d want v=1 cnt=20 occ=3", q_if.iss_valid, q_if.iss_entry.instr_count, occupancy); end
        flush       = 1'b1;
        flush_count = 32'd19;
        @(negedge clk);
        flush = 1'b0;
        vectors++; if (q_if.iss_valid !== 1'b0 || occupancy !== 4'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL fl_output_kill: got v=%b occ=%0d empty=%b want v=0 occ=0 empty=1", q_if.iss_valid, occupancy, empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        q_if.iss_ready = 1'b0;
        q_if.enq_valid = 1'b1;
        q_if.enq_entry = mk(70, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        q_if.enq_entry = mk(71, 6'd1, 6'd2, 1'b1, 1'b1);
        @(negedge clk);
        q_if.enq_valid = 1'b0;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b1 || occupancy !== 4'd1) begin miscompares++; $display("FAIL ar_setup: got v=%b occ=%0d want v=1 occ=1", q_if.iss_valid, occupancy); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (q_if.iss_valid !== 1'b0 || occupancy !== 4'd0) begin miscompares++; $display("FAIL ar_immediate: got v=%b occ=%0d want v=0 occ=0", q_if.iss_valid, occupancy); end
        vectors++; if (q_if.iss_entry !== '0 || empty !== 1'b1) begin miscompares++; $display("FAIL ar_entry: got entry=%h empty=%b want 0/1", q_if.iss_entry, empty); end
        @(negedge clk);
        rst_n = 1'b1;
        q_if.iss_ready = 1'b1;
        @(negedge clk);
        vectors++; if (q_if.iss_valid !== 1'b0 || q_if.enq_ready !== 1'b1) begin miscompares++; $display("FAIL ar_discard: got v=%b rdy=%b want v=0 rdy=1", q_if.iss_valid, q_if.enq_ready); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_in_order();
        test_wakeup();
        test_full();
        test_stall();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default INSTR_QUEUE_SIZE (8): number of queue slots, any value 2..32.
REQ-002 SHALL have parameter PREG_W, default 6: physical register tag width; NUM_PREGS = 2**PREG_W.
REQ-003 SHALL have parameter WAKE_PORTS, default 2: number of result-tag wakeup broadcast ports.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports enq_valid  input  1  and  enq_ready  output  1: enqueue handshake.
REQ-007 SHALL have port enq_entry  input  Instr_Queue_Entry_t  instruction payload, including rs_phys, rt_phys, rw_phys, uses_rs, uses_rt and instr_count[31:0].
REQ-008 SHALL have port busy_bits  input  NUM_PREGS  busy table; bit=1 means value pending.
REQ-009 SHALL have ports wake_valid  input  WAKE_PORTS  and  wake_tag  input  WAKE_PORTS x PREG_W: completed-result broadcasts.
REQ-010 SHALL have ports iss_valid  output  1,  iss_ready  input  1 (low = execute stall), and  iss_entry  output  Instr_Queue_Entry_t.
REQ-011 SHALL have ports flush  input  1  and  flush_count  input  32: branch-recovery squash.
REQ-012 SHALL have ports occupancy  output  $clog2(DEPTH+1)  and  empty  output  1.

Function
REQ-013 Each slot SHALL hold valid, rs_rdy, rt_rdy and the entry; an operand not used SHALL be marked ready.
REQ-014 enq_ready SHALL equal (occupancy < DEPTH) & ~flush, using registered occupancy only; a slot freed by issue in the same cycle is not reusable until the next cycle.
REQ-015 On enq_valid & enq_ready the entry SHALL be written into the lowest-index free slot at the clock edge.
REQ-016 Enqueue operand readiness SHALL be ~busy_bits[tag] OR a matching wake_valid/wake_tag in the same cycle.
REQ-017 Every cycle, each valid slot whose rs_phys or rt_phys matches any asserted wake_tag SHALL set the corresponding ready bit.
REQ-018 A slot is eligible when valid & rs_rdy & rt_rdy; the select SHALL pick the eligible slot with the smallest instr_count (oldest first), ties impossible.
REQ-019 The output register SHALL load the selected entry, and that slot SHALL be freed, at an edge where (~iss_valid | iss_ready) and an eligible slot exists; otherwise iss_valid SHALL drop to 0 when iss_ready is high.
REQ-020 While iss_valid & ~iss_ready, iss_entry and iss_valid SHALL hold stable and no slot SHALL be freed.
REQ-021 Minimum latency: an entry enqueued ready at edge E SHALL appear on iss_valid after edge E+1.
REQ-022 On flush, every slot and the output register whose instr_count > flush_count (unsigned) SHALL be invalidated at that edge; older entries SHALL be kept, wakeups still applied; no enqueue or issue load SHALL occur that cycle.
REQ-023 occupancy SHALL count valid slots only (excluding the output register); empty = (occupancy == 0) & ~iss_valid.
REQ-024 Simultaneous enqueue and issue SHALL update occupancy by net +0.

Reset
REQ-025 On rst_n low, all slot valid bits, iss_valid and occupancy SHALL clear immediately, regardless of clk; iss_entry SHALL be zero.
REQ-026 After reset release, enq_ready SHALL be 1 and empty SHALL be 1; reset asserted mid-operation SHALL discard all contents.

Structure
REQ-027 Instr_Queue_Entry_t, INSTR_QUEUE_SIZE and the PREG_W default SHALL live in mips_core_pkg.
REQ-028 The oldest-eligible selection SHALL be one sub-module, iq_oldest_select (DEPTH-wide eligible vector plus counts in; one-hot grant and found out).

Verification
REQ-029 Enqueue counts 10, 11, 12, all operands ready, iss_ready=1 -> issue order 10, 11, 12 on consecutive cycles, first after edge E+1.
REQ-030 Enqueue count 5 with rs busy (tag 7), then count 6 ready -> 6 issues first; wake_tag=7 -> 5 issues next cycle.
REQ-031 Fill DEPTH=8 slots with busy operands -> enq_ready=0 and occupancy=8; one wakeup and issue -> enq_ready=1 the cycle after the issue.
REQ-032 Valid output held with iss_ready=0 for 3 cycles -> iss_entry stable; iss_ready=1 -> next oldest loads at that edge.
REQ-033 Slots with counts 20..27 and flush=1, flush_count=23 -> slots 24..27 invalidated, occupancy=4, enqueue in that cycle ignored.
REQ-034 rst_n low mid-stream between clock edges -> iss_valid=0 and occupancy=0 immediately.
